// File: rtl/fp32_to_fp16_share_ctrl_pkg.sv
// fp_conv_pkg: fp32/fp16 format constants, fp32 field slices and range flags
package fp_conv_pkg;
  localparam int FP32_BIAS = 127;
  localparam int FP16_BIAS = 15;
  localparam int FP16_EMAX = 15;
  localparam int FP16_EMIN = -14;
  localparam int F32_EXP_W = 8;
  localparam int F32_MAN_W = 23;
  localparam int F16_EXP_W = 5;
  localparam int F16_MAN_W = 10;
  typedef struct packed {
    logic [F16_EXP_W+F16_MAN_W:0] data;
    logic ovf;
    logic unf;
  } conv_res_t;
  function automatic logic f32_sign(input logic [31:0] x);
    return x[31];
  endfunction
  function automatic logic [F32_EXP_W-1:0] f32_exp(input logic [31:0] x);
    return x[30:23];
  endfunction
  function automatic logic [F32_MAN_W-1:0] f32_man(input logic [31:0] x);
    return x[22:0];
  endfunction
  function automatic int f32_uexp(input logic [31:0] x);
    return int'(f32_exp(x)) - FP32_BIAS;
  endfunction
  function automatic logic f32_ovf(input logic [31:0] x);
    return f32_exp(x) != '1 && f32_uexp(x) > FP16_EMAX;
  endfunction
  function automatic logic f32_unf(input logic [31:0] x);
    return f32_exp(x) != '1 && (f32_exp(x) != '0 || f32_man(x) != '0) && f32_uexp(x) < FP16_EMIN;
  endfunction
endpackage

// File: rtl/fp32_to_fp16.sv
// fp32_to_fp16: truncating fp32->fp16 conversion, saturating to Inf, denormal/zero on underflow
module fp32_to_fp16
  import fp_conv_pkg::*;
(
  input  logic [31:0] a,
  output logic [15:0] y
);
  logic s;
  logic [F32_EXP_W-1:0] e;
  logic [F32_MAN_W-1:0] m;
  logic [F16_MAN_W-1:0] nan_m, den_m;
  always_comb begin
    s = f32_sign(a);
    e = f32_exp(a);
    m = f32_man(a);
    nan_m = m[22 -: F16_MAN_W] | {{(F16_MAN_W-1){1'b0}}, ~|m[22 -: F16_MAN_W] & |m};
    den_m = F16_MAN_W'({1'b1, m} >> (8'(FP32_BIAS - 1) - e));
    y = e == '1 ? {s, 5'h1f, nan_m} :
        f32_ovf(a) ? {s, 5'h1f, 10'd0} :
        f32_uexp(a) >= FP16_EMIN ? {s, 5'(e - 8'(FP32_BIAS - FP16_BIAS)), m[22 -: F16_MAN_W]} :
        {s, 5'd0, den_m};
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin search starting at ptr, one-hot grant plus index
module rr_arbiter #(
  parameter int N = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] idx
);
  logic [N-1:0] m;
  always_comb begin
    gnt = '0;
    idx = '0;
    m = '0;
    for (int i = N - 1; i >= 0; i--) begin
      m = N'(1) << ((int'(ptr) + i) % N);
      if (|(req & m)) begin
        gnt = m;
        idx = ID_W'((int'(ptr) + i) % N);
      end
    end
  end
endmodule

// File: rtl/fp32_to_fp16_share_ctrl.sv
// fp32_to_fp16_share_ctrl: round-robin shares one fp32->fp16 converter over a 2-stage pipeline
module fp32_to_fp16_share_ctrl
  import fp_conv_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           out_data,
  output logic [ID_W-1:0]       out_id,
  output logic                  out_ovf,
  output logic                  out_unf,
  output logic [CNT_W-1:0]      conv_cnt,
  output logic                  busy
);
  logic s1_valid, s2_valid, s1_load, s2_load, accept;
  logic [31:0] s1_data;
  logic [ID_W-1:0] s1_id, s2_id, rr_ptr, g_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [15:0] conv;
  logic [31:0] req_words [NUM_REQ];
  conv_res_t s2_res;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign req_words[i] = req_data[32*i +: 32];
  end
  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (.req(req_valid), .ptr(rr_ptr), .gnt(gnt), .idx(g_idx));
  fp32_to_fp16 u_conv (.a(s1_data), .y(conv));
  always_comb begin
    s2_load = s1_valid & (~s2_valid | out_ready);
    s1_load = ~s1_valid | s2_load;
    req_ready = s1_load ? gnt : '0;
    accept = |(req_valid & req_ready);
  end
  assign out_valid = s2_valid;
  assign out_data = s2_res.data;
  assign out_id = s2_id;
  assign out_ovf = s2_res.ovf;
  assign out_unf = s2_res.unf;
  assign busy = s1_valid | s2_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_res <= '0;
      s2_id <= '0;
      conv_cnt <= '0;
      rr_ptr <= '0;
    end else begin
      if (s1_load) s1_valid <= accept;
      if (accept) begin
        s1_data <= req_words[g_idx];
        s1_id <= g_idx;
        rr_ptr <= g_idx == ID_W'(NUM_REQ - 1) ? '0 : g_idx + 1'b1;
      end
      if (s2_load) begin
        s2_res <= '{conv, f32_ovf(s1_data), f32_unf(s1_data)};
        s2_id <= s1_id;
        s2_valid <= 1'b1;
      end else if (out_ready) s2_valid <= 1'b0;
      if (s2_valid & out_ready) conv_cnt <= conv_cnt + 1'b1;
    end
  end
endmodule
